dec_entry: RTL and testbench

- Decimal keypad-entry block for the Basys3 Hack CPU board; it is the input-side counterpart of the 7-segment display path.
- The user edits four BCD digits (thousands..ones) with the five pushbuttons and commits with the centre button.
- On commit, the block converts the BCD value to 16-bit binary with a sequential multiply-by-10 accumulator.
- The result is offered to the CPU/memory-mapped input register through a valid/ready handshake.
- The live digits and cursor are exported so the display can echo the entry.

---
 rtl/dec_entry_pkg.sv | 14 +
 rtl/dec_entry_btn_debounce.sv | 37 +++
 rtl/dec_entry.sv | 111 +++++++++++
 tb/tb_dec_entry.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/dec_entry_pkg.sv
// Shared types and constants for the decimal keypad-entry block.
package dec_entry_pkg;
  typedef enum logic [1:0] {IDLE, CONV, HOLD} state_t;

  localparam int         NUM_DIGITS = 4;
  localparam logic [3:0] BCD_MAX    = 4'd9;

  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_ENTER = 4;
  localparam int NUM_BTNS  = 5;
endpackage

// File: rtl/dec_entry_btn_debounce.sv
// Button path: 2-flop synchronizer, stability counter, one-cycle press pulse on accepted rise.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int DB_W            = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);
  logic            sync1, sync2, level;
  logic [DB_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        // Level accepted; only a rising acceptance produces a pulse.
        level <= sync2;
        cnt   <= '0;
        press <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/dec_entry.sv
// Four-digit BCD keypad entry with sequential BCD-to-binary conversion and valid/ready output.
//   state | meaning
//   IDLE  | buttons edit digits/cursor; enter starts a conversion
//   CONV  | one digit per cycle, thousands first (k = 3..0)
//   HOLD  | result offered on data_out until data_ready
module dec_entry
  import dec_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int DB_W            = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_enter,
  output logic [15:0] data_out,
  output logic        data_valid,
  input  logic        data_ready,
  output logic [15:0] digits_bcd,
  output logic [1:0]  cursor,
  output logic        busy
);
  logic [NUM_BTNS-1:0] btn_raw, press;

  assign btn_raw[BTN_UP]    = btn_up;
  assign btn_raw[BTN_DOWN]  = btn_down;
  assign btn_raw[BTN_LEFT]  = btn_left;
  assign btn_raw[BTN_RIGHT] = btn_right;
  assign btn_raw[BTN_ENTER] = btn_enter;

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_db
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .DB_W           (DB_W)
    ) u_db (
      .clk  (clk),
      .rst_n(rst_n),
      .btn  (btn_raw[i]),
      .press(press[i])
    );
  end

  state_t                    state;
  logic [NUM_DIGITS-1:0][3:0] digits;
  logic [13:0]               acc, acc_next;
  logic [1:0]                k;
  logic [3:0]                cur_digit, digit_inc, digit_dec;

  assign digits_bcd = digits;
  assign cur_digit  = digits[cursor];
  assign digit_inc  = (cur_digit == BCD_MAX) ? 4'd0 : cur_digit + 4'd1;
  assign digit_dec  = (cur_digit == 4'd0) ? BCD_MAX : cur_digit - 4'd1;
  // acc*10 as shift-and-add; 14 bits holds 9999 so no step overflows.
  assign acc_next   = (acc << 3) + (acc << 1) + {10'd0, digits[k]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      digits     <= '0;
      cursor     <= 2'd0;
      acc        <= '0;
      k          <= 2'd0;
      data_out   <= 16'd0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (press[BTN_ENTER]) begin
            state <= CONV;
            acc   <= '0;
            k     <= 2'd3;
            busy  <= 1'b1;
          end else if (press[BTN_UP]) begin
            digits[cursor] <= digit_inc;
          end else if (press[BTN_DOWN]) begin
            digits[cursor] <= digit_dec;
          end else if (press[BTN_LEFT]) begin
            cursor <= cursor + 2'd1;
          end else if (press[BTN_RIGHT]) begin
            cursor <= cursor - 2'd1;
          end
        end
        CONV: begin
          acc <= acc_next;
          k   <= k - 2'd1;
          if (k == 2'd0) begin
            state      <= HOLD;
            data_out   <= {2'b00, acc_next};
            data_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (data_ready) begin
            state      <= IDLE;
            data_valid <= 1'b0;
            busy       <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          data_valid <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dec_entry.sv
// Scoreboard bench for dec_entry with a short debounce window.
module tb_dec_entry;
  import dec_entry_pkg::*;

  localparam logic [4:0] M_UP    = 5'(1 << BTN_UP);
  localparam logic [4:0] M_DOWN  = 5'(1 << BTN_DOWN);
  localparam logic [4:0] M_LEFT  = 5'(1 << BTN_LEFT);
  localparam logic [4:0] M_RIGHT = 5'(1 << BTN_RIGHT);
  localparam logic [4:0] M_ENTER = 5'(1 << BTN_ENTER);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  btn = '0;
  logic        data_ready = 1'b1;
  logic [15:0] data_out, digits_bcd;
  logic        data_valid, busy;
  logic [1:0]  cursor;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] exp_q[$];
  logic [3:0]  m_dig[4];
  logic [1:0]  m_cur;

  always #5 clk = ~clk;

  dec_entry #(.DEBOUNCE_CYCLES(4), .DB_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_up    (btn[BTN_UP]),
    .btn_down  (btn[BTN_DOWN]),
    .btn_left  (btn[BTN_LEFT]),
    .btn_right (btn[BTN_RIGHT]),
    .btn_enter (btn[BTN_ENTER]),
    .data_out  (data_out),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .digits_bcd(digits_bcd),
    .cursor    (cursor),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] m_bcd();
    return {m_dig[3], m_dig[2], m_dig[1], m_dig[0]};
  endfunction

  function automatic logic [15:0] m_bin();
    int v;
    v = m_dig[3] * 1000 + m_dig[2] * 100 + m_dig[1] * 10 + m_dig[0];
    return 16'(v);
  endfunction

  task automatic m_apply(input logic [4:0] mask);
    if (mask[BTN_ENTER]) return;
    if (mask[BTN_UP])         m_dig[m_cur] = (m_dig[m_cur] == 4'd9) ? 4'd0 : m_dig[m_cur] + 4'd1;
    else if (mask[BTN_DOWN])  m_dig[m_cur] = (m_dig[m_cur] == 4'd0) ? 4'd9 : m_dig[m_cur] - 4'd1;
    else if (mask[BTN_LEFT])  m_cur = (m_cur == 2'd3) ? 2'd0 : m_cur + 2'd1;
    else if (mask[BTN_RIGHT]) m_cur = (m_cur == 2'd0) ? 2'd3 : m_cur - 2'd1;
  endtask

  // Clean press: 10 cycles held, 10 released; use_model=0 for presses that must be ignored.
  task automatic press(input logic [4:0] mask, input bit use_model);
    @(negedge clk) btn = mask;
    repeat (10) @(negedge clk);
    btn = '0;
    repeat (10) @(negedge clk);
    if (use_model) m_apply(mask);
    check("digits", 32'(digits_bcd), 32'(m_bcd()));
    check("cursor", 32'(cursor), 32'(m_cur));
  endtask

  task automatic set_value(input logic [15:0] v);
    for (int p = 0; p < 4; p++) begin
      while (m_cur != 2'(p)) press(M_LEFT, 1'b1);
      while (m_dig[p] != v[p*4 +: 4]) press(M_UP, 1'b1);
    end
  endtask

  // Commit: the busy rise marks the cycle after the enter pulse; valid must follow 4 cycles later.
  task automatic commit(input logic [4:0] mask);
    int t;
    exp_q.push_back(m_bin());
    @(negedge clk) btn = mask;
    t = 0;
    while (!busy && t < 50) begin @(negedge clk); t++; end
    check("busy_rise", 32'(busy), 32'd1);
    t = 0;
    while (!data_valid && t < 20) begin @(negedge clk); t++; end
    check("latency", 32'(t), 32'd4);
    btn = '0;
    repeat (12) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst_n && data_valid && data_ready) begin
      check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("sb_data", 32'(data_out), 32'(exp_q.pop_front()));
      @(negedge clk);
      check("valid_drop", 32'(data_valid), 32'd0);
    end
  end

  initial begin
    int t;
    for (int i = 0; i < 4; i++) m_dig[i] = 4'd0;
    m_cur = 2'd0;

    repeat (3) @(negedge clk);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_valid", 32'(data_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_digits", 32'(digits_bcd), 32'd0);
    check("rst_cursor", 32'(cursor), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 2-cycle glitch must be rejected
    btn = M_UP;
    repeat (2) @(negedge clk);
    btn = '0;
    repeat (10) @(negedge clk);
    check("glitch", 32'(digits_bcd), 32'h0000);

    press(M_UP, 1'b1);
    check("one_inc", 32'(digits_bcd), 32'h0001);

    set_value(16'h1234);
    commit(M_ENTER);
    check("idle_after_1234", 32'(busy), 32'd0);
    check("hold_1234", 32'(data_out), 32'h04D2);

    // cursor wraps
    press(M_LEFT, 1'b1);
    check("left_wrap", 32'(cursor), 32'd0);
    press(M_RIGHT, 1'b1);
    check("right_wrap", 32'(cursor), 32'd3);

    press(M_DOWN, 1'b1);
    press(M_DOWN, 1'b1);
    check("down_wrap", 32'(digits_bcd[15:12]), 32'd9);

    set_value(16'h9999);
    commit(M_ENTER);
    check("out_9999", 32'(data_out), 32'h270F);

    press(M_UP, 1'b1);
    check("up_wrap", 32'(digits_bcd[15:12]), 32'd0);

    set_value(16'h0000);
    commit(M_ENTER);
    check("out_0000", 32'(data_out), 32'h0000);

    // simultaneous up+left: only the digit changes
    press(M_UP | M_LEFT, 1'b1);
    check("simul_digits", 32'(digits_bcd), 32'h1000);

    // enter beats up: pre-increment value converted, digits untouched
    commit(M_ENTER | M_UP);
    check("enter_up_digits", 32'(digits_bcd), 32'h1000);
    check("enter_up_out", 32'(data_out), 32'h03E8);

    // backpressure
    set_value(16'h0042);
    data_ready = 1'b0;
    commit(M_ENTER);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(data_valid), 32'd1);
      check("bp_data", 32'(data_out), 32'h002A);
      check("bp_busy", 32'(busy), 32'd1);
    end
    press(M_UP, 1'b0);
    check("bp_still_valid", 32'(data_valid), 32'd1);
    data_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("bp_release_busy", 32'(busy), 32'd0);
    check("bp_release_valid", 32'(data_valid), 32'd0);

    // reset during the second CONV cycle
    @(negedge clk) btn = M_ENTER;
    t = 0;
    while (!busy && t < 50) begin @(negedge clk); t++; end
    check("conv_busy", 32'(busy), 32'd1);
    btn = '0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_valid", 32'(data_valid), 32'd0);
    check("mid_rst_digits", 32'(digits_bcd), 32'd0);
    check("mid_rst_cursor", 32'(cursor), 32'd0);
    check("mid_rst_data", 32'(data_out), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) m_dig[i] = 4'd0;
    m_cur = 2'd0;
    repeat (10) @(negedge clk);
    check("post_rst_valid", 32'(data_valid), 32'd0);
    check("post_rst_data", 32'(data_out), 32'd0);

    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
